// File: rtl/h_matrix_streamer_if.sv
// Load and multiplier-facing buses of h_matrix_streamer.
// master: the streamer; slave: the loader / matrix_multiplier side.
interface h_matrix_streamer_if #(
  parameter int N = 16
) ();
  logic         ld_valid;
  logic         ld_ready;
  logic [N-1:0] ld_r;
  logic [N-1:0] ld_i;
  logic         ld_clear;
  logic         mm_start;
  logic [3:0]   mm_q_index;
  logic         mm_H_valid;
  logic [N-1:0] mm_H_r;
  logic [N-1:0] mm_H_i;
  logic         mm_hq_valid;

  modport master (
    input  ld_valid, ld_r, ld_i, ld_clear, mm_hq_valid,
    output ld_ready, mm_start, mm_q_index, mm_H_valid, mm_H_r, mm_H_i
  );

  modport slave (
    output ld_valid, ld_r, ld_i, ld_clear, mm_hq_valid,
    input  ld_ready, mm_start, mm_q_index, mm_H_valid, mm_H_r, mm_H_i
  );
endinterface

// File: rtl/h_matrix_streamer.sv
// Buffers one column-major H matrix and replays it row-major once per q_index.
// Optional macro HQ_TIMEOUT_EN adds a WAIT_HQ watchdog and the timeout_err output.
//
// state     | meaning
// S_IDLE    | loading / waiting for run_start
// S_START   | 1-cycle mm_start, Hq count cleared
// S_STREAM  | ROWS*COLS row-major H beats
// S_WAIT_HQ | waiting for ROWS*2 Hq beats of the pass
// S_GAP     | GAP_CYCLES idle cycles before the next pass
// S_DONE    | 1-cycle done pulse
module h_matrix_streamer #(
  parameter int N          = 16,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int GAP_CYCLES = 2
`ifdef HQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 256
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  h_matrix_streamer_if.master bus,
  input  logic                run_start,
  input  logic [3:0]          q_first,
  input  logic [3:0]          q_last,
  output logic                h_loaded,
  output logic                busy,
  output logic                done,
  output logic [3:0]          cur_q,
  output logic                err_nobuf,
  output logic                hq_overrun
`ifdef HQ_TIMEOUT_EN
  ,
  output logic                timeout_err
`endif
);
  localparam int NB       = ROWS * COLS;
  localparam int AW       = (NB > 1) ? $clog2(NB) : 1;
  localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW       = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int HQ_BEATS = ROWS * 2;
  localparam int HW       = $clog2(HQ_BEATS + 1);
  localparam int GW       = $clog2(GAP_CYCLES + 1);
`ifdef HQ_TIMEOUT_EN
  localparam int TW       = $clog2(TIMEOUT + 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_STREAM, S_WAIT_HQ, S_GAP, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  h_r [NB];
  logic [N-1:0]  h_i [NB];
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_ptr;
  logic [3:0]    q_end;
  logic [HW-1:0] hq_cnt;
  logic [GW-1:0] gap_cnt;
  logic          ld_fire, rd_last, hq_full, last_pass, start_ok;
`ifdef HQ_TIMEOUT_EN
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  assign tmo_hit = (tmo_cnt == '0);
`endif

  assign bus.ld_ready = (state_q == S_IDLE) && !h_loaded && !bus.ld_clear;
  assign ld_fire      = bus.ld_valid && bus.ld_ready;
  // storage is row-major so the replay is a plain incrementing read
  assign wr_addr      = AW'(int'(wr_row) * COLS + int'(wr_col));
  assign rd_last      = (rd_ptr == AW'(NB - 1));
  assign hq_full      = (hq_cnt == HW'(HQ_BEATS));
  assign last_pass    = (cur_q == q_end);
  assign start_ok     = (state_q == S_IDLE) && run_start && h_loaded;

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign bus.mm_start   = (state_q == S_START);
  assign bus.mm_q_index = cur_q;
  assign bus.mm_H_valid = (state_q == S_STREAM);
  assign bus.mm_H_r     = bus.mm_H_valid ? h_r[rd_ptr] : '0;
  assign bus.mm_H_i     = bus.mm_H_valid ? h_i[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (ld_fire) begin
      h_r[wr_addr] <= bus.ld_r;
      h_i[wr_addr] <= bus.ld_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_ok) state_d = S_START;
      S_START:   state_d = S_STREAM;
      S_STREAM:  if (rd_last) state_d = S_WAIT_HQ;
      S_WAIT_HQ: begin
        if (hq_full) state_d = last_pass ? S_DONE : S_GAP;
`ifdef HQ_TIMEOUT_EN
        else if (tmo_hit) state_d = S_IDLE;
`endif
      end
      S_GAP:     if (gap_cnt == '0) state_d = S_START;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_loaded   <= 1'b0;
      wr_row     <= '0;
      wr_col     <= '0;
      rd_ptr     <= '0;
      cur_q      <= '0;
      q_end      <= '0;
      hq_cnt     <= '0;
      gap_cnt    <= '0;
      err_nobuf  <= 1'b0;
      hq_overrun <= 1'b0;
    end else begin
      err_nobuf <= (state_q == S_IDLE) && run_start && !h_loaded;
      if (state_q == S_IDLE) begin
        if (bus.ld_clear) begin
          h_loaded <= 1'b0;
          wr_row   <= '0;
          wr_col   <= '0;
        end else if (ld_fire) begin
          if (wr_row == RW'(ROWS - 1)) begin
            wr_row <= '0;
            if (wr_col == CW'(COLS - 1)) begin
              wr_col   <= '0;
              h_loaded <= 1'b1;
            end else begin
              wr_col <= wr_col + CW'(1);
            end
          end else begin
            wr_row <= wr_row + RW'(1);
          end
        end
      end
      if (start_ok) begin
        cur_q <= q_first;
        q_end <= q_last;
      end else if (state_q == S_WAIT_HQ && hq_full && !last_pass) begin
        cur_q <= cur_q + 4'd1;
      end
      if (state_q == S_START)       rd_ptr <= '0;
      else if (state_q == S_STREAM) rd_ptr <= rd_ptr + AW'(1);
      if (state_d == S_GAP && state_q != S_GAP) gap_cnt <= GW'(GAP_CYCLES - 1);
      else if (state_q == S_GAP)                gap_cnt <= gap_cnt - GW'(1);
      // a beat in the START cycle is the first of the new pass
      if (state_q == S_START) begin
        hq_cnt <= bus.mm_hq_valid ? HW'(1) : '0;
      end else if (state_q != S_IDLE && bus.mm_hq_valid) begin
        if (hq_full) hq_overrun <= 1'b1;
        else         hq_cnt     <= hq_cnt + HW'(1);
      end
    end
  end

`ifdef HQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_d == S_WAIT_HQ && state_q != S_WAIT_HQ) tmo_cnt <= TW'(TIMEOUT - 1);
      else if (state_q == S_WAIT_HQ && !tmo_hit)        tmo_cnt <= tmo_cnt - TW'(1);
      if (state_q == S_WAIT_HQ && !hq_full && tmo_hit) timeout_err <= 1'b1;
    end
  end
`endif
endmodule
